cl_word_unpacker: RTL and testbench
===================================

Name: cl_word_unpacker

Overview:
- Sits between a cache-line FIFO read port (clfifo_read: re_tdata/re_tvalid/re_tready) and a word FIFO write port (wordfifo_write: we/wdata, with almostfull).
- Splits each 512-bit cache line into 16 32-bit words, least-significant word first.
- Emits exactly a programmed number of words per job, discards the unused tail of the last line, then pulses done.
- Used by the GLM machine to feed prefetched sample data into word-granular compute and prefetch buffers.

Parameters:
- LINE_WIDTH, 512, cache-line width in bits.
- WORD_WIDTH, 32, output word width in bits.
- WORDS_PER_LINE, LINE_WIDTH/WORD_WIDTH (16), derived; not overridden independently.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  job start pulse; sampled only in IDLE.
- num_words  input  32  total words to emit for the job; latched on accepted start.
- line_tvalid  input  1  cache-line FIFO data valid.
- line_tready  output  1  cache-line pop; handshake = line_tvalid & line_tready.
- line_tdata  input  LINE_WIDTH  cache-line data.
- word_we  output  1  word FIFO write enable, registered.
- word_wdata  output  WORD_WIDTH  word FIFO write data, registered.
- word_almostfull  input  1  word FIFO backpressure.
- busy  output  1  high from accepted start until DONE is exited.
- done  output  1  one-cycle completion pulse.
- words_emitted  output  32  words written this job; held after done until next start.

Behaviour:

Reset:
- State goes to IDLE.
- line_tready=0, word_we=0, word_wdata=0, busy=0, done=0, words_emitted=0.
- Internal line register, word index and remaining counter are cleared.
- Reset mid-job: the partial line is discarded, no done pulse, and the cycle after reset deasserts shows all outputs at reset values.

States:
- IDLE
  - On start with num_words==0: go to DONE.
  - On start with num_words!=0: latch remaining=num_words, clear words_emitted, set busy=1, go to LOAD.
  - line_tready=0 in IDLE.
- LOAD
  - line_tready=1, combinationally decoded from state.
  - On handshake: capture line_tdata, set idx=0, go to EMIT.
  - No handshake: stay in LOAD.
- EMIT
  - line_tready=0.
  - Each cycle with word_almostfull=0: next cycle word_we=1 and word_wdata=line[idx*32 +: 32]. Then idx++, remaining--, words_emitted++.
  - Cycle with word_almostfull=1: word_we=0 next cycle and no counter change.
  - After an emit, if remaining reaches 0, go to DONE, even if idx<15; the rest of the line is dropped.
  - Otherwise, if idx was 15, go to LOAD.
  - Otherwise stay in EMIT.
- DONE
  - done=1 for exactly this cycle. busy stays 1 for this cycle; busy=0 from the next cycle.
  - Go to IDLE.

Handshake and start rules:
- start while not in IDLE is ignored.
- line_tvalid outside LOAD is never consumed.

Timing and latency:
- Line handshake in cycle t: EMIT is entered at t+1 and the first word_we is visible at t+2.
- Steady-state throughput is 16 words per 17 cycles (one LOAD cycle per line, with line_tvalid held high).
- Because word_we is registered, at most one word can already be in flight when almostfull rises. The word FIFO's almostfull threshold must leave at least 2 free entries.

Width and ordering:
- Word k of a line is bits [32k+31 : 32k].
- remaining and words_emitted are 32-bit unsigned, with no wrap within a job.
- Word order across lines is preserved exactly.

Test Plan:
1. num_words=16, one line whose word k=0x100+k -> 16 writes 0x100..0x10F in order; first word_we 2 cycles after the handshake; exactly 1 line handshake; a single done pulse; words_emitted=16.
2. num_words=20, two lines (line 2 word k=0x200+k) -> 20 writes ending 0x200..0x203; line_tready never high after the 2nd handshake; a 3rd line stays in the FIFO; done once.
3. start with num_words=0 -> done high exactly 1 cycle after start; no line_tready; no word_we; words_emitted=0.
4. num_words=16, word_almostfull high for 5 cycles after the 4th write -> at most 1 extra write after the assertion, then none until release; the sequence 0x100..0x10F stays complete and ordered.
5. reset high for 1 cycle mid-EMIT of job num_words=32 -> next cycle word_we=0, busy=0, done never pulses; a new job with num_words=16 then completes normally.
6. start pulsed while busy, and line_tvalid=1 held in IDLE -> second start ignored (words_emitted matches the first job); no line consumed while in IDLE.

Source files
------------

// File: rtl/cl_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : cl_word_unpacker
// Purpose  : Pops cache lines and writes them out as words, least-significant
//            word first, stopping after a programmed word count per job.
// Revision : 1.0
// ============================================================================
module cl_word_unpacker #(
    parameter int LINE_WIDTH     = 512,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           num_words,
    input  logic                  line_tvalid,
    output logic                  line_tready,
    input  logic [LINE_WIDTH-1:0] line_tdata,
    output logic                  word_we,
    output logic [WORD_WIDTH-1:0] word_wdata,
    input  logic                  word_almostfull,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           words_emitted
);

    localparam int IDX_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             remaining_q, remaining_d;
    logic [31:0]             words_emitted_q, words_emitted_d;
    logic                    word_we_q, word_we_d;
    logic [WORD_WIDTH-1:0]   word_wdata_q, word_wdata_d;
    logic [WORD_WIDTH-1:0]   w_cur_word;
    logic                    w_line_hs;

    always_comb begin
        w_cur_word = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_cur_word = line_q[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign w_line_hs = line_tvalid & line_tready;

    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        idx_d           = idx_q;
        remaining_d     = remaining_q;
        words_emitted_d = words_emitted_q;
        word_we_d       = 1'b0;
        word_wdata_d    = word_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d     = num_words;
                    words_emitted_d = '0;
                    state_d         = (num_words == 32'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_line_hs) begin
                    line_d  = line_tdata;
                    idx_d   = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                // Almostfull stalls emission; the registered write already in flight still lands.
                if (!word_almostfull) begin
                    word_we_d       = 1'b1;
                    word_wdata_d    = w_cur_word;
                    idx_d           = idx_q + 1'b1;
                    remaining_d     = remaining_q - 32'd1;
                    words_emitted_d = words_emitted_q + 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = S_DONE;
                    end else if (idx_q == C_LAST_IDX) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            line_q          <= '0;
            idx_q           <= '0;
            remaining_q     <= '0;
            words_emitted_q <= '0;
            word_we_q       <= 1'b0;
            word_wdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            line_q          <= line_d;
            idx_q           <= idx_d;
            remaining_q     <= remaining_d;
            words_emitted_q <= words_emitted_d;
            word_we_q       <= word_we_d;
            word_wdata_q    <= word_wdata_d;
        end
    end

    assign line_tready   = (state_q == S_LOAD);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign word_we       = word_we_q;
    assign word_wdata    = word_wdata_q;
    assign words_emitted = words_emitted_q;

endmodule
`default_nettype wire

// File: tb/tb_cl_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cl_word_unpacker
// Purpose  : Self-checking bench for cl_word_unpacker with a line-source model
//            and a flat word-stream reference.
// Revision : 1.0
// ============================================================================
module tb_cl_word_unpacker;

    localparam int LW  = 512;
    localparam int WW  = 32;
    localparam int WPL = LW / WW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   num_words = '0;
    logic          line_tvalid = 1'b0;
    logic          line_tready;
    logic [LW-1:0] line_tdata = '0;
    logic          word_we;
    logic [WW-1:0] word_wdata;
    logic          word_almostfull = 1'b0;
    logic          busy;
    logic          done;
    logic [31:0]   words_emitted;

    always #5 clk = ~clk;

    cl_word_unpacker #(
        .LINE_WIDTH     (LW),
        .WORD_WIDTH     (WW),
        .WORDS_PER_LINE (WPL)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_words       (num_words),
        .line_tvalid     (line_tvalid),
        .line_tready     (line_tready),
        .line_tdata      (line_tdata),
        .word_we         (word_we),
        .word_wdata      (word_wdata),
        .word_almostfull (word_almostfull),
        .busy            (busy),
        .done            (done),
        .words_emitted   (words_emitted)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // line source: written by tests (push / flush_to), consumed by the source process
    logic [LW-1:0] src[$];
    int            src_rd      = 0;
    int            src_hs_seen = 0;
    int            flush_to    = 0;
    bit            src_rand    = 1'b0;
    bit            src_en      = 1'b1;

    // monitor records
    int            cyc = 0;
    logic [WW-1:0] got[$];
    int            got_cyc[$];
    int            hs_count = 0;
    int            hs_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            start_cyc = -1;
    int            tready_cnt = 0;
    int            tready_last = -1;
    int            extra_af = 0;
    bit            af_rand = 1'b0;
    int            af_trig_at = -1;
    int            af_fired_at = -1;
    int            af_left = 0;

    logic [LW-1:0] exp_lines[$];

    always @(posedge clk) begin
        #1;
        while (src_hs_seen < hs_count) begin
            src_hs_seen++;
            src_rd++;
        end
        if (src_rd < flush_to) src_rd = flush_to;
        src_en      = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        line_tvalid = src_en && (src_rd < src.size());
        line_tdata  = (src_rd < src.size()) ? src[src_rd] : '0;
    end

    always @(negedge clk) begin
        cyc++;
        if (line_tready === 1'b1) begin
            tready_cnt++;
            tready_last = cyc;
        end
        if (line_tvalid && (line_tready === 1'b1) && !reset) begin
            hs_count++;
            hs_cyc.push_back(cyc);
        end
        if (word_we === 1'b1) begin
            got.push_back(word_wdata);
            got_cyc.push_back(cyc);
            if (word_almostfull) extra_af++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start && (busy === 1'b0)) start_cyc = cyc;
        if (af_rand) begin
            word_almostfull = ($urandom_range(0, 3) == 0);
        end else if (af_left > 0) begin
            af_left--;
            word_almostfull = (af_left != 0);
        end else if ((got.size() == af_trig_at) && (af_fired_at != af_trig_at)) begin
            af_fired_at     = af_trig_at;
            af_left         = 5;
            word_almostfull = 1'b1;
        end else begin
            word_almostfull = 1'b0;
        end
    end

    function automatic logic [LW-1:0] ramp(input int base);
        logic [LW-1:0] l;
        for (int k = 0; k < WPL; k++) l[k*WW +: WW] = WW'(base + k);
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < WPL; k++) l[k*WW +: WW] = $urandom();
        return l;
    endfunction

    // Word i of the job is word (i mod 16) of line (i div 16).
    function automatic logic [WW-1:0] exp_word(input int i);
        logic [LW-1:0] l;
        l = exp_lines[i / WPL];
        return l[(i % WPL)*WW +: WW];
    endfunction

    task automatic add_line(input logic [LW-1:0] l);
        src.push_back(l);
        exp_lines.push_back(l);
    endtask

    task automatic flush_src();
        flush_to = src.size();
        exp_lines.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_words = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (line_tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", line_tready); else n_pass++;
        n_checks++; if (word_we !== 1'b0) $display("FAIL reset_we: got %b want 0", word_we); else n_pass++;
        n_checks++; if (word_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", word_wdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (words_emitted !== 32'd0) $display("FAIL reset_emitted: got %0d want 0", words_emitted); else n_pass++;
    endtask

    task automatic test_single_line();
        int g0, h0, d0, lat;
        bit ok;
        flush_src();
        g0 = got.size(); h0 = hs_count; d0 = done_cnt;
        add_line(ramp(32'h100));
        pulse_start(32'd16);
        wait_done(d0, 200, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got.size() - g0 != 16) $display("FAIL single_count: got %0d want 16", got.size() - g0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[g0+i] !== exp_word(i)) $display("FAIL single_word%0d: got %h want %h", i, got[g0+i], exp_word(i));
            else n_pass++;
        end
        lat = (got.size() > g0 && hs_cyc.size() > h0) ? got_cyc[g0] - hs_cyc[h0] : -1;
        n_checks++; if (lat != 2) $display("FAIL single_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (hs_count - h0 != 1) $display("FAIL single_handshakes: got %0d want 1", hs_count - h0); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL single_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (words_emitted !== 32'd16) $display("FAIL single_emitted: got %0d want 16", words_emitted); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_two_lines();
        int g0, h0, d0, last_hs;
        bit ok;
        flush_src();
        g0 = got.size(); h0 = hs_count; d0 = done_cnt;
        add_line(ramp(32'h100));
        add_line(ramp(32'h200));
        add_line(ramp(32'h300));
        pulse_start(32'd20);
        wait_done(d0, 300, ok);
        n_checks++; if (!ok) $display("FAIL two_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got.size() - g0 != 20) $display("FAIL two_count: got %0d want 20", got.size() - g0); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (got[g0+i] !== exp_word(i)) $display("FAIL two_word%0d: got %h want %h", i, got[g0+i], exp_word(i));
            else n_pass++;
        end
        n_checks++; if (hs_count - h0 != 2) $display("FAIL two_handshakes: got %0d want 2", hs_count - h0); else n_pass++;
        last_hs = (hs_cyc.size() > h0 + 1) ? hs_cyc[h0+1] : -2;
        n_checks++; if (tready_last != last_hs) $display("FAIL two_tready_after: got last %0d want %0d", tready_last, last_hs); else n_pass++;
        n_checks++; if (src.size() - src_rd != 1) $display("FAIL two_leftover: got %0d want 1", src.size() - src_rd); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL two_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (words_emitted !== 32'd20) $display("FAIL two_emitted: got %0d want 20", words_emitted); else n_pass++;
    endtask

    task automatic test_zero_words();
        int g0, d0, t0;
        bit ok;
        flush_src();
        g0 = got.size(); d0 = done_cnt; t0 = tready_cnt;
        pulse_start(32'd0);
        wait_done(d0, 20, ok);
        n_checks++; if (!ok) $display("FAIL zero_timeout: got no done want done"); else n_pass++;
        n_checks++; if (done_cyc - start_cyc != 1) $display("FAIL zero_latency: got %0d want 1", done_cyc - start_cyc); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL zero_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (tready_cnt != t0) $display("FAIL zero_tready: got %0d want %0d", tready_cnt, t0); else n_pass++;
        n_checks++; if (got.size() != g0) $display("FAIL zero_writes: got %0d want 0", got.size() - g0); else n_pass++;
        n_checks++; if (words_emitted !== 32'd0) $display("FAIL zero_emitted: got %0d want 0", words_emitted); else n_pass++;
    endtask

    task automatic test_backpressure();
        int g0, d0, e0, span;
        bit ok;
        flush_src();
        g0 = got.size(); d0 = done_cnt; e0 = extra_af;
        af_trig_at = g0 + 4;
        add_line(ramp(32'h100));
        pulse_start(32'd16);
        wait_done(d0, 300, ok);
        n_checks++; if (!ok) $display("FAIL bp_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got.size() - g0 != 16) $display("FAIL bp_count: got %0d want 16", got.size() - g0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[g0+i] !== exp_word(i)) $display("FAIL bp_word%0d: got %h want %h", i, got[g0+i], exp_word(i));
            else n_pass++;
        end
        n_checks++; if (extra_af - e0 > 1) $display("FAIL bp_extra: got %0d want <=1", extra_af - e0); else n_pass++;
        span = (got.size() >= g0 + 16) ? got_cyc[g0+15] - got_cyc[g0] : -1;
        n_checks++; if (span < 19) $display("FAIL bp_stall: got span %0d want >=19", span); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL bp_done: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset_midjob();
        int g0, d0;
        bit ok, seen;
        flush_src();
        g0 = got.size(); d0 = done_cnt;
        add_line(rand_line());
        add_line(rand_line());
        pulse_start(32'd32);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (got.size() >= g0 + 5) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) $display("FAIL rst_mid_timeout: got %0d words want 5", got.size() - g0); else n_pass++;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (word_we !== 1'b0) $display("FAIL rst_mid_we: got %b want 0", word_we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (line_tready !== 1'b0) $display("FAIL rst_mid_tready: got %b want 0", line_tready); else n_pass++;
        n_checks++; if (words_emitted !== 32'd0) $display("FAIL rst_mid_emitted: got %0d want 0", words_emitted); else n_pass++;
        flush_src();
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != d0) $display("FAIL rst_mid_done: got %0d want 0", done_cnt - d0); else n_pass++;
        g0 = got.size(); d0 = done_cnt;
        add_line(rand_line());
        pulse_start(32'd16);
        wait_done(d0, 200, ok);
        n_checks++; if (!ok) $display("FAIL rst_mid_rerun_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got.size() - g0 != 16) $display("FAIL rst_mid_rerun_count: got %0d want 16", got.size() - g0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[g0+i] !== exp_word(i)) $display("FAIL rst_mid_word%0d: got %h want %h", i, got[g0+i], exp_word(i));
            else n_pass++;
        end
        n_checks++; if (words_emitted !== 32'd16) $display("FAIL rst_mid_emitted2: got %0d want 16", words_emitted); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int g0, h0, d0;
        bit ok;
        flush_src();
        g0 = got.size(); h0 = hs_count; d0 = done_cnt;
        add_line(ramp(32'h1000));
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (hs_count != h0) $display("FAIL ign_idle_hs: got %0d want 0", hs_count - h0); else n_pass++;
        n_checks++; if (src.size() - src_rd != 1) $display("FAIL ign_idle_kept: got %0d want 1", src.size() - src_rd); else n_pass++;
        pulse_start(32'd16);
        repeat (3) @(posedge clk);
        pulse_start(32'd5);
        wait_done(d0, 200, ok);
        n_checks++; if (!ok) $display("FAIL ign_timeout: got no done want done"); else n_pass++;
        n_checks++; if (words_emitted !== 32'd16) $display("FAIL ign_emitted: got %0d want 16", words_emitted); else n_pass++;
        n_checks++; if (got.size() - g0 != 16) $display("FAIL ign_count: got %0d want 16", got.size() - g0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[g0+i] !== exp_word(i)) $display("FAIL ign_word%0d: got %h want %h", i, got[g0+i], exp_word(i));
            else n_pass++;
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL ign_done: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (hs_count - h0 != 1) $display("FAIL ign_hs: got %0d want 1", hs_count - h0); else n_pass++;
    endtask

    task automatic test_random();
        int g0, h0, d0, e0, n, nl;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            flush_src();
            g0 = got.size(); h0 = hs_count; d0 = done_cnt; e0 = extra_af;
            n  = $urandom_range(1, 60);
            nl = (n + WPL - 1) / WPL;
            for (int l = 0; l < nl; l++) add_line(rand_line());
            src_rand = 1'b1;
            af_rand  = 1'b1;
            pulse_start(32'(n));
            wait_done(d0, 2000, ok);
            src_rand = 1'b0;
            af_rand  = 1'b0;
            n_checks++; if (!ok) $display("FAIL rnd%0d_timeout: got no done want done", it); else n_pass++;
            n_checks++; if (got.size() - g0 != n) $display("FAIL rnd%0d_count: got %0d want %0d", it, got.size() - g0, n); else n_pass++;
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (got[g0+i] !== exp_word(i)) $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, got[g0+i], exp_word(i));
                else n_pass++;
            end
            n_checks++; if (hs_count - h0 != nl) $display("FAIL rnd%0d_hs: got %0d want %0d", it, hs_count - h0, nl); else n_pass++;
            n_checks++; if (extra_af != e0) $display("FAIL rnd%0d_af_write: got %0d want 0", it, extra_af - e0); else n_pass++;
            n_checks++; if (words_emitted !== 32'(n)) $display("FAIL rnd%0d_emitted: got %0d want %0d", it, words_emitted, n); else n_pass++;
            n_checks++; if (done_cnt - d0 != 1) $display("FAIL rnd%0d_done: got %0d want 1", it, done_cnt - d0); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_two_lines();
        test_zero_words();
        test_backpressure();
        test_reset_midjob();
        test_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
